// File: rtl/hls_macc_motion_pkg.sv
// Shared definitions for the key-locked motion MACC kernel.
//  - one-hot block-level FSM state encoding
//  - working-key width and the bit offset of every keyed field
//  - OBF_MASK: the literal vector is recovered as working_key ^ OBF_MASK
//  - CORRECT_KEY: unlock value, for benches only; never used by the RTL
package hls_macc_motion_pkg;

  typedef enum logic [3:0] {
    S1 = 4'b0001,
    S2 = 4'b0010,
    S3 = 4'b0100,
    S4 = 4'b1000
  } state_t;

  localparam int KW = 32;

  // Key field layout. Shift fields reserve 8 bits; only the low SHW bits are used.
  localparam int K_SHL   = 0;
  localparam int K_SHR   = 8;
  localparam int K_IDLE  = 16;
  localparam int K_READY = 17;
  localparam int K_DONE  = 18;
  localparam int K_VLD   = 19;
  localparam int K_ST    = 20;  // 4 bits, one compare literal per one-hot state bit

  localparam logic [7:0] SHL_TRUE = 8'd2;
  localparam logic [7:0] SHR_TRUE = 8'd3;

  // Literal values the hardware needs when unlocked.
  localparam logic [KW-1:0] TRUE_LITS = {8'h00, 4'hF, 4'hF, SHR_TRUE, SHL_TRUE};

  localparam logic [KW-1:0] OBF_MASK    = 32'h6B1D_C4A7;
  localparam logic [KW-1:0] CORRECT_KEY = OBF_MASK ^ TRUE_LITS;

  function automatic logic [KW-1:0] key_lits(input logic [KW-1:0] working_key);
    return working_key ^ OBF_MASK;
  endfunction

endpackage

// File: rtl/hls_macc_motion_dp.sv
// Datapath of the motion MACC kernel: three register stages, each with its own
// load enable. The controller decides when each stage advances.
//  Stage A: operand capture (en_a)
//  Stage B: inner sums and products (en_b)
//  Stage C: final results out1..out3 (en_c), reset to zero
// Ports:
//  ap_clk, ap_rst_n      clock, async active-low reset (stage C only)
//  en_a, en_b, en_c      per-stage load enables
//  shl, shr              decoded shift amounts for the out2/out3 middle terms
//  in1..in10             operands
//  out1..out3            registered results
// All arithmetic is unsigned DW-bit: the low DW bits of signed and unsigned
// add/multiply are identical, and the right shift has to be logical.
module hls_macc_motion_dp #(
  parameter int DW  = 32,
  parameter int SHW = 5
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic          en_a,
  input  logic          en_b,
  input  logic          en_c,
  input  logic [SHW-1:0] shl,
  input  logic [SHW-1:0] shr,
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  input  logic [DW-1:0] in3,
  input  logic [DW-1:0] in4,
  input  logic [DW-1:0] in5,
  input  logic [DW-1:0] in6,
  input  logic [DW-1:0] in7,
  input  logic [DW-1:0] in8,
  input  logic [DW-1:0] in9,
  input  logic [DW-1:0] in10,
  output logic [DW-1:0] out1,
  output logic [DW-1:0] out2,
  output logic [DW-1:0] out3
);

  logic [DW-1:0] a1, a2, a3, a4, a5, a6, a7, a8, a9, a10;
  logic [DW-1:0] b_x1, b_x3, b_x4, b_x5, b_x9;
  logic [DW-1:0] b_t1, b_p54, b_t2b, b_p63, b_s72;
  logic [DW-1:0] b_p86, b_t3b, b_p87, b_t3d;
  logic [DW-1:0] mid2, mid3;

  // NOTE: stages A and B carry no reset; their contents only matter once the
  // controller's valid tracking says so, and stage C is what the outside sees.
  always_ff @(posedge ap_clk) begin
    if (en_a) begin
      a1 <= in1;  a2 <= in2;  a3 <= in3;  a4 <= in4;  a5 <= in5;
      a6 <= in6;  a7 <= in7;  a8 <= in8;  a9 <= in9;  a10 <= in10;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (en_b) begin
      b_x1  <= a1;
      b_x3  <= a3;
      b_x4  <= a4;
      b_x5  <= a5;
      b_x9  <= a9;
      b_t1  <= a2 + a3 * a1;
      b_p54 <= a5 * a4;
      b_t2b <= a2 + a7 * a4;
      b_p63 <= a6 * a3;
      b_s72 <= a7 + a2;
      b_p86 <= a8 * a6;
      b_t3b <= a7 + a10 * a10;
      b_p87 <= a8 * a7;
      b_t3d <= a8 + a9 * a6;
    end
  end

  // Middle terms are truncated to DW bits before shifting.
  assign mid2 = b_x5 * b_t2b + b_p63;
  assign mid3 = b_x9 * b_t3b + b_p87;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out1 <= '0;
      out2 <= '0;
      out3 <= '0;
    end else if (en_c) begin
      out1 <= b_x1 * b_t1;
      out2 <= b_x4 * b_p54 + (mid2 << shl) + b_x3 * b_s72;
      out3 <= b_p86 + (mid3 >> shr) + b_x4 * b_t3d;
    end
  end

endmodule

// File: rtl/hls_macc_motion_pipe_obf.sv
// Key-locked motion MACC kernel with ap_ctrl handshake plus ap_continue.
//  PIPELINED=0: one-hot FSM S1..S4, one job in flight, one job per 4 cycles.
//  PIPELINED=1: valid chain, II=1, stall = result held and not continued.
//  Accept-to-done latency is 3 cycles in both modes.
// Ports:
//  ap_clk, ap_rst_n             clock, async active-low reset
//  ap_start / ap_ready          job request / inputs captured this cycle
//  ap_done / outN_ap_vld        result valid on out1..out3
//  ap_continue                  consumer takes the current result
//  ap_idle                      no job in flight
//  in1..in10, out1..out3        operands and registered results
//  locking_key                  unlock key; low KW bits form the working key
// Every control literal and both shift amounts come from the working key.
// Control outputs are gated by live_q, a flop that comes out of reset one cycle
// after release, so reset-time output levels never depend on the key.
module hls_macc_motion_pipe_obf
  import hls_macc_motion_pkg::*;
#(
  parameter int DW        = 32,
  parameter int PIPELINED = 0,
  parameter int SHW       = 5,
  parameter int LK_W      = 3071
) (
  input  logic            ap_clk,
  input  logic            ap_rst_n,
  input  logic            ap_start,
  input  logic            ap_continue,
  output logic            ap_ready,
  output logic            ap_done,
  output logic            ap_idle,
  input  logic [DW-1:0]   in1,
  input  logic [DW-1:0]   in2,
  input  logic [DW-1:0]   in3,
  input  logic [DW-1:0]   in4,
  input  logic [DW-1:0]   in5,
  input  logic [DW-1:0]   in6,
  input  logic [DW-1:0]   in7,
  input  logic [DW-1:0]   in8,
  input  logic [DW-1:0]   in9,
  input  logic [DW-1:0]   in10,
  output logic [DW-1:0]   out1,
  output logic [DW-1:0]   out2,
  output logic [DW-1:0]   out3,
  output logic            out1_ap_vld,
  output logic            out2_ap_vld,
  output logic            out3_ap_vld,
  input  logic [LK_W-1:0] locking_key
);

  logic [KW-1:0]  lit;
  logic [SHW-1:0] shl, shr;
  logic           unused_key;
  logic           live_q;
  logic           en_a, en_b, en_c;
  logic           ready_raw, done_raw, idle_raw;
  logic           vld_lvl;

  assign lit        = key_lits(locking_key[KW-1:0]);
  assign shl        = lit[K_SHL +: SHW];
  assign shr        = lit[K_SHR +: SHW];
  assign unused_key = ^{locking_key[LK_W-1:KW], lit};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) live_q <= 1'b0;
    else           live_q <= 1'b1;
  end

  generate
    if (PIPELINED != 0) begin : g_pipe
      logic [3:1] v_q;
      logic       stall;
      logic       accept;

      assign stall  = v_q[3] & ~ap_continue;
      assign accept = live_q & ap_start & ~stall;

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)   v_q <= '0;
        else if (!stall) v_q <= {v_q[2:1], accept};
      end

      assign en_a      = ~stall;
      assign en_b      = ~stall;
      assign en_c      = ~stall;
      assign ready_raw = accept;
      assign done_raw  = v_q[3];
      assign idle_raw  = ~|v_q & ~ap_start;
    end else begin : g_fsm
      state_t     state_q, state_d;
      logic [3:0] in_s;
      logic       accept;

      // Bitwise equality of each state bit against its keyed literal.
      assign in_s   = state_q ~^ lit[K_ST +: 4];
      assign accept = live_q & in_s[0] & ap_start;

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state_q <= S1;
        else           state_q <= state_d;
      end

      // NOTE: state_d gets its default first, so no path leaves it unassigned
      // and no latch is inferred.
      always_comb begin
        state_d = state_q;
        if (in_s[0]) begin
          if (accept) state_d = S2;
        end else if (in_s[1]) begin
          state_d = S3;
        end else if (in_s[2]) begin
          state_d = S4;
        end else if (in_s[3]) begin
          if (ap_continue) state_d = S1;
        end else begin
          state_d = S1;
        end
      end

      assign en_a      = accept;
      assign en_b      = in_s[1];
      assign en_c      = in_s[2];
      assign ready_raw = accept;
      assign done_raw  = in_s[3];
      assign idle_raw  = in_s[0];
    end
  endgenerate

  assign ap_ready    = live_q & (ready_raw ~^ lit[K_READY]);
  assign ap_done     = live_q & (done_raw  ~^ lit[K_DONE]);
  assign vld_lvl     = live_q & (done_raw  ~^ lit[K_VLD]);
  assign ap_idle     = ~live_q | (idle_raw ~^ lit[K_IDLE]);
  assign out1_ap_vld = vld_lvl;
  assign out2_ap_vld = vld_lvl;
  assign out3_ap_vld = vld_lvl;

  hls_macc_motion_dp #(
    .DW  (DW),
    .SHW (SHW)
  ) u_dp (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .en_a     (en_a),
    .en_b     (en_b),
    .en_c     (en_c),
    .shl      (shl),
    .shr      (shr),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .in4      (in4),
    .in5      (in5),
    .in6      (in6),
    .in7      (in7),
    .in8      (in8),
    .in9      (in9),
    .in10     (in10),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3)
  );

endmodule

// File: tb/tb_hls_macc_motion_pipe_obf.sv
// Bench for hls_macc_motion_pipe_obf: one FSM-mode and one pipelined instance
// sharing clock, reset, operands and key. Inputs change on the falling edge,
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_hls_macc_motion_pipe_obf;
  import hls_macc_motion_pkg::*;

  localparam int DW   = 32;
  localparam int LK_W = 3071;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_f, cont_f, start_p, cont_p;
  logic            ready_f, done_f, idle_f, ready_p, done_p, idle_p;
  logic [2:0]      vld_f, vld_p;
  logic [DW-1:0]   op    [10];
  logic [DW-1:0]   out_f [3];
  logic [DW-1:0]   out_p [3];
  logic [LK_W-1:0] key;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] v1 [10];
  logic [DW-1:0] vec [8][10];
  logic [95:0]   expv [8];

  always #5 clk = ~clk;

  hls_macc_motion_pipe_obf #(.DW(DW), .PIPELINED(0), .SHW(5), .LK_W(LK_W)) dut_fsm (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start_f), .ap_continue(cont_f),
    .ap_ready(ready_f), .ap_done(done_f), .ap_idle(idle_f),
    .in1(op[0]), .in2(op[1]), .in3(op[2]), .in4(op[3]), .in5(op[4]),
    .in6(op[5]), .in7(op[6]), .in8(op[7]), .in9(op[8]), .in10(op[9]),
    .out1(out_f[0]), .out2(out_f[1]), .out3(out_f[2]),
    .out1_ap_vld(vld_f[0]), .out2_ap_vld(vld_f[1]), .out3_ap_vld(vld_f[2]),
    .locking_key(key)
  );

  hls_macc_motion_pipe_obf #(.DW(DW), .PIPELINED(1), .SHW(5), .LK_W(LK_W)) dut_pipe (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start_p), .ap_continue(cont_p),
    .ap_ready(ready_p), .ap_done(done_p), .ap_idle(idle_p),
    .in1(op[0]), .in2(op[1]), .in3(op[2]), .in4(op[3]), .in5(op[4]),
    .in6(op[5]), .in7(op[6]), .in8(op[7]), .in9(op[8]), .in10(op[9]),
    .out1(out_p[0]), .out2(out_p[1]), .out3(out_p[2]),
    .out1_ap_vld(vld_p[0]), .out2_ap_vld(vld_p[1]), .out3_ap_vld(vld_p[2]),
    .locking_key(key)
  );

  // Direct evaluation of the three output formulas, DW-bit wrap.
  function automatic logic [95:0] ref_calc(input logic [DW-1:0] a [10], input int sl, input int sr);
    logic [DW-1:0] o1, o2, o3, l, r;
    o1 = a[0] * (a[1] + a[2] * a[0]);
    l  = a[4] * (a[1] + a[6] * a[3]) + a[5] * a[2];
    o2 = a[3] * (a[4] * a[3]) + (l << sl) + a[2] * (a[6] + a[1]);
    r  = a[8] * (a[6] + a[9] * a[9]) + a[7] * a[6];
    o3 = a[7] * a[5] + (r >> sr) + a[3] * (a[7] + a[8] * a[5]);
    return {o1, o2, o3};
  endfunction

  task automatic set_ops(input logic [DW-1:0] a [10]);
    for (int i = 0; i < 10; i++) op[i] = a[i];
  endtask

  task automatic set_correct_key();
    key = '0;
    key[KW-1:0] = CORRECT_KEY;
  endtask

  // One job with continue held high; operands are scrambled after the accept
  // cycle. lat = cycles from accept to done, 0 if done never came.
  task automatic run_job(input bit pipe, input logic [DW-1:0] a [10], output bit rdy,
                         output int lat, output logic [DW-1:0] o [3], output logic [2:0] vld);
    @(negedge clk);
    set_ops(a);
    if (pipe) begin start_p = 1'b1; cont_p = 1'b1; end
    else      begin start_f = 1'b1; cont_f = 1'b1; end
    #1 rdy = pipe ? ready_p : ready_f;
    lat = 0;
    o   = '{default: '0};
    vld = '0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start_p = 1'b0;
        start_f = 1'b0;
        for (int i = 0; i < 10; i++) op[i] = 32'hDEAD_0000 + 32'(i);
      end
      #1;
      if (pipe ? done_p : done_f) begin
        lat = c;
        o   = pipe ? out_p : out_f;
        vld = pipe ? vld_p : vld_f;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_f = 1'b1; start_p = 1'b1;
    cont_f = 1'b1;  cont_p = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({ready_f, done_f, idle_f, vld_f} !== 6'b001000) begin
      errors++;
      $display("FAIL reset_ctrl_fsm: got %b expected 001000", {ready_f, done_f, idle_f, vld_f});
    end
    checks++;
    if ({ready_p, done_p, idle_p, vld_p} !== 6'b001000) begin
      errors++;
      $display("FAIL reset_ctrl_pipe: got %b expected 001000", {ready_p, done_p, idle_p, vld_p});
    end
    checks++;
    if ({out_f[0], out_f[1], out_f[2]} !== 96'd0) begin
      errors++;
      $display("FAIL reset_out_fsm: got %h expected 0", {out_f[0], out_f[1], out_f[2]});
    end
    checks++;
    if ({out_p[0], out_p[1], out_p[2]} !== 96'd0) begin
      errors++;
      $display("FAIL reset_out_pipe: got %h expected 0", {out_p[0], out_p[1], out_p[2]});
    end
    start_f = 1'b0; start_p = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit rdy; int lat; logic [DW-1:0] o [3]; logic [2:0] vld;
    for (int m = 0; m < 2; m++) begin
      run_job(m[0], v1, rdy, lat, o, vld);
      checks++;
      if (rdy !== 1'b1) begin errors++; $display("FAIL basic_ready m%0d: got %b expected 1", m, rdy); end
      checks++;
      if (lat != 3) begin errors++; $display("FAIL basic_latency m%0d: got %0d expected 3", m, lat); end
      checks++;
      if (o[0] !== 32'd5) begin errors++; $display("FAIL basic_out1 m%0d: got %0d expected 5", m, o[0]); end
      checks++;
      if (o[1] !== 32'd779) begin errors++; $display("FAIL basic_out2 m%0d: got %0d expected 779", m, o[1]); end
      checks++;
      if (o[2] !== 32'd423) begin errors++; $display("FAIL basic_out3 m%0d: got %0d expected 423", m, o[2]); end
      checks++;
      if (vld !== 3'b111) begin errors++; $display("FAIL basic_vld m%0d: got %b expected 111", m, vld); end
    end
  endtask

  task automatic test_wrap();
    bit rdy; int lat; logic [DW-1:0] o [3]; logic [2:0] vld;
    logic [DW-1:0] a [10];
    a = v1;
    a[0] = 32'h0001_0000; a[2] = 32'h0001_0000; a[1] = 32'd0;
    run_job(1'b0, a, rdy, lat, o, vld);
    checks++;
    if (o[0] !== 32'd0) begin errors++; $display("FAIL wrap_out1: got %0d expected 0", o[0]); end
    checks++;
    if (o[1] !== 32'd2032256) begin errors++; $display("FAIL wrap_out2: got %0d expected 2032256", o[1]); end
    checks++;
    if (o[2] !== 32'd423) begin errors++; $display("FAIL wrap_out3: got %0d expected 423", o[2]); end
  endtask

  task automatic test_hold();
    int wait_c;
    @(negedge clk);
    set_ops(v1);
    start_f = 1'b1; cont_f = 1'b0;
    wait_c = 0;
    do begin
      @(negedge clk); #1;
      wait_c++;
    end while (!done_f && wait_c < 10);
    checks++;
    if (done_f !== 1'b1) begin errors++; $display("FAIL hold_reach_done: got %b expected 1", done_f); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({done_f, ready_f, out_f[0], out_f[1], out_f[2]} !== {1'b1, 1'b0, 32'd5, 32'd779, 32'd423}) begin
        errors++;
        $display("FAIL hold_cycle%0d: got done=%b ready=%b outs=%0d,%0d,%0d expected 1 0 5,779,423",
                 c, done_f, ready_f, out_f[0], out_f[1], out_f[2]);
      end
    end
    cont_f = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (ready_f !== 1'b1 || done_f !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: got ready=%b done=%b expected ready=1 done=0", ready_f, done_f);
    end
    @(negedge clk) start_f = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int tx, rx;
    logic [DW-1:0] a [10];
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 10; i++) begin
        vec[j][i] = 32'(j * 37 + i * 11 + 3);
        if ((i + j) % 3 == 0) vec[j][i] = -vec[j][i];
        a[i] = vec[j][i];
      end
      expv[j] = ref_calc(a, 2, 3);
    end
    tx = 0; rx = 0;
    for (int cyc = 0; cyc < 80 && rx < 8; cyc++) begin
      @(negedge clk);
      start_p = (tx < 8);
      if (tx < 8) for (int i = 0; i < 10; i++) op[i] = vec[tx][i];
      cont_p = ((cyc % 4) != 1) && ((cyc % 7) != 5);
      #1;
      if (done_p && cont_p) begin
        checks++;
        if ({out_p[0], out_p[1], out_p[2]} !== expv[rx]) begin
          errors++;
          $display("FAIL b2b_result%0d: got %h expected %h", rx, {out_p[0], out_p[1], out_p[2]}, expv[rx]);
        end
        rx++;
      end
      if (ready_p) tx++;
    end
    checks++;
    if (rx != 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", rx); end
    start_p = 1'b0; cont_p = 1'b1;
    begin
      int extra = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk); #1;
        if (done_p) extra++;
      end
      checks++;
      if (extra != 0) begin errors++; $display("FAIL b2b_no_dup: got %0d extra done cycles expected 0", extra); end
    end
  endtask

  task automatic test_reset_mid_job();
    int dones = 0;
    @(negedge clk);
    set_ops(v1);
    start_f = 1'b1; cont_f = 1'b1;
    @(negedge clk) start_f = 1'b0;      // now in S2
    @(negedge clk);                     // now in S3
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready_f, done_f, idle_f, vld_f} !== 6'b001000) begin
      errors++;
      $display("FAIL midrst_ctrl: got %b expected 001000", {ready_f, done_f, idle_f, vld_f});
    end
    checks++;
    if ({out_f[0], out_f[1], out_f[2], out_p[0], out_p[1], out_p[2]} !== 192'd0) begin
      errors++;
      $display("FAIL midrst_outs: got %0d,%0d,%0d expected 0", out_f[0], out_f[1], out_f[2]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (done_f || done_p) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL midrst_no_done: got %0d done cycles expected 0", dones); end
  endtask

  task automatic test_key();
    bit rdy; int lat; logic [DW-1:0] o [3]; logic [2:0] vld;
    bit xseen = 1'b0;
    // One SHL key bit flipped: SHL becomes 3.
    set_correct_key();
    key[K_SHL] = ~key[K_SHL];
    run_job(1'b0, v1, rdy, lat, o, vld);
    checks++;
    if (o[1] !== 32'd1451) begin errors++; $display("FAIL key_shl_bit_out2: got %0d expected 1451", o[1]); end
    checks++;
    if (o[0] !== 32'd5) begin errors++; $display("FAIL key_shl_bit_out1: got %0d expected 5", o[0]); end
    // Both shift fields corrupted: SHL=22, SHR=17.
    set_correct_key();
    key[31:0] = key[31:0] ^ 32'h0000_1234;
    run_job(1'b0, v1, rdy, lat, o, vld);
    checks++;
    if (o[1] !== 32'd704643179) begin errors++; $display("FAIL key_shift_out2: got %0d expected 704643179", o[1]); end
    checks++;
    if (o[2] !== 32'd296) begin errors++; $display("FAIL key_shift_out3: got %0d expected 296", o[2]); end
    // Random key: behaviour is wrong but must stay X-free.
    key = '0;
    key[31:0]  = $urandom;
    key[63:32] = $urandom;
    if (key[31:0] == CORRECT_KEY) key[0] = ~key[0];
    set_ops(v1);
    start_f = 1'b1; cont_f = 1'b1; start_p = 1'b1; cont_p = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if ((^{ready_f, done_f, idle_f, vld_f, out_f[0], out_f[1], out_f[2],
             ready_p, done_p, idle_p, vld_p, out_p[0], out_p[1], out_p[2]}) === 1'bx) xseen = 1'b1;
    end
    checks++;
    if (xseen) begin errors++; $display("FAIL key_random_xfree: got X on outputs expected none"); end
    start_f = 1'b0; start_p = 1'b0;
    set_correct_key();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_job(1'b0, v1, rdy, lat, o, vld);
    checks++;
    if (o[1] !== 32'd779 || lat != 3) begin
      errors++;
      $display("FAIL key_recover: got out2=%0d lat=%0d expected 779 lat 3", o[1], lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 10; i++) v1[i] = 32'(i + 1);
    set_correct_key();
    set_ops(v1);
    test_reset();
    test_basic();
    test_wrap();
    test_hold();
    test_back_to_back();
    test_reset_mid_job();
    test_key();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
